// File: rtl/mem_bus_ctrl.sv
// Data-memory access sequencer for the MEM stage: drives the shared Ram1 SRAM
// bus and the on-board UART, stalling the pipeline through Busy until done.
module mem_bus_ctrl #(
  parameter logic [15:0] UART_DATA_ADDR = 16'hBF00,
  parameter logic [15:0] UART_STAT_ADDR = 16'hBF01,
  parameter int unsigned WR_PULSE       = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [15:0] Addr,
  input  logic [15:0] WData,
  output logic [15:0] RData,
  output logic        Done,
  output logic        Busy,
  output logic        Ram1_EN,
  output logic        Ram1_OE,
  output logic        Ram1_WE,
  output logic [17:0] Ram1_address,
  inout  wire  [15:0] Ram1_data,
  output logic        rdn,
  output logic        wrn,
  input  logic        data_ready,
  input  logic        tbre,
  input  logic        tsre
);

  typedef enum logic [3:0] {
    IDLE,
    RAM_RD,
    RAM_WR_SETUP,
    RAM_WR_PULSE,
    RAM_WR_HOLD,
    STAT,
    UART_RD_WAIT,
    UART_RD_PULSE,
    UART_WR_SETUP,
    UART_WR_PULSE,
    UART_WR_WAIT_TBRE,
    UART_WR_WAIT_TSRE,
    DONE
  } state_t;

  state_t      state, nextState;
  logic [15:0] addrQ;
  logic [15:0] dataQ;
  logic [2:0]  pulseCnt;
  logic        driveEn;

  assign Busy         = (MemRead | MemWrite) & ~Done;
  assign Ram1_address = {2'b00, addrQ};
  assign Ram1_data    = driveEn ? dataQ : 16'bz;

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (MemWrite) begin
          if (Addr == UART_STAT_ADDR)      nextState = DONE;
          else if (Addr == UART_DATA_ADDR) nextState = UART_WR_SETUP;
          else                             nextState = RAM_WR_SETUP;
        end else if (MemRead) begin
          if (Addr == UART_STAT_ADDR)      nextState = STAT;
          else if (Addr == UART_DATA_ADDR) nextState = UART_RD_WAIT;
          else                             nextState = RAM_RD;
        end
      end
      RAM_RD:            nextState = DONE;
      RAM_WR_SETUP:      nextState = RAM_WR_PULSE;
      RAM_WR_PULSE:      if (pulseCnt == '0) nextState = RAM_WR_HOLD;
      RAM_WR_HOLD:       nextState = DONE;
      STAT:              nextState = DONE;
      UART_RD_WAIT:      if (data_ready) nextState = UART_RD_PULSE;
      UART_RD_PULSE:     nextState = DONE;
      UART_WR_SETUP:     nextState = UART_WR_PULSE;
      UART_WR_PULSE:     nextState = UART_WR_WAIT_TBRE;
      UART_WR_WAIT_TBRE: if (tbre) nextState = UART_WR_WAIT_TSRE;
      UART_WR_WAIT_TSRE: if (tsre) nextState = DONE;
      DONE:              nextState = IDLE;
      default:           nextState = IDLE;
    endcase
  end

  // Strobes are decoded from the state being entered so they are registered
  // and line up exactly with the state they belong to.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state    <= IDLE;
      Ram1_EN  <= 1'b1;
      Ram1_OE  <= 1'b1;
      Ram1_WE  <= 1'b1;
      rdn      <= 1'b1;
      wrn      <= 1'b1;
      driveEn  <= 1'b0;
      Done     <= 1'b0;
      RData    <= '0;
      addrQ    <= '0;
      dataQ    <= '0;
      pulseCnt <= '0;
    end else begin
      state   <= nextState;
      Ram1_EN <= !(nextState inside {RAM_RD, RAM_WR_SETUP, RAM_WR_PULSE, RAM_WR_HOLD});
      Ram1_OE <= !(nextState == RAM_RD);
      Ram1_WE <= !(nextState == RAM_WR_PULSE);
      rdn     <= !(nextState == UART_RD_PULSE);
      wrn     <= !(nextState == UART_WR_PULSE);
      driveEn <= nextState inside {RAM_WR_SETUP, RAM_WR_PULSE, RAM_WR_HOLD,
                                   UART_WR_SETUP, UART_WR_PULSE};
      Done    <= (nextState == DONE);

      if (state == IDLE && (MemRead || MemWrite)) begin
        addrQ <= Addr;
        dataQ <= (MemWrite && Addr == UART_DATA_ADDR) ? {8'h00, WData[7:0]} : WData;
      end

      // Loaded on the setup edge, counts down while WE is low.
      if (state == RAM_WR_SETUP)
        pulseCnt <= 3'(WR_PULSE - 1);
      else if (state == RAM_WR_PULSE && pulseCnt != '0)
        pulseCnt <= pulseCnt - 3'd1;

      case (state)
        RAM_RD:        RData <= Ram1_data;
        STAT:          RData <= {14'b0, data_ready, tbre & tsre};
        UART_RD_PULSE: RData <= {8'h00, Ram1_data[7:0]};
        default:       ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: table of accesses driven through a shared runner,
// with SRAM/UART bus models and a scoreboard of expected completions.
module tb_mem_bus_ctrl;

  localparam int WR_PULSE = 2;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [15:0] Addr = '0;
  logic [15:0] WData = '0;
  logic [15:0] RData;
  logic        Done, Busy, Ram1_EN, Ram1_OE, Ram1_WE, rdn, wrn;
  logic [17:0] Ram1_address;
  wire  [15:0] Ram1_data;
  logic        data_ready = 1'b0;
  logic        tbre = 1'b0;
  logic        tsre = 1'b0;

  logic [15:0] sram [0:255];
  logic [7:0]  uartByte = 8'h5A;
  logic        probe = 1'b0;

  int nChecks = 0;
  int nFail = 0;

  always #5 Clk = ~Clk;

  mem_bus_ctrl #(
    .UART_DATA_ADDR(16'hBF00),
    .UART_STAT_ADDR(16'hBF01),
    .WR_PULSE(WR_PULSE)
  ) dut (
    .Clk(Clk), .Rst(Rst), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WData(WData), .RData(RData), .Done(Done), .Busy(Busy),
    .Ram1_EN(Ram1_EN), .Ram1_OE(Ram1_OE), .Ram1_WE(Ram1_WE),
    .Ram1_address(Ram1_address), .Ram1_data(Ram1_data),
    .rdn(rdn), .wrn(wrn), .data_ready(data_ready), .tbre(tbre), .tsre(tsre)
  );

  // SRAM answers reads, UART answers rdn (junk upper byte), probe pulls to 0.
  assign Ram1_data = (!Ram1_EN && !Ram1_OE) ? sram[Ram1_address[7:0]] :
                     (!rdn ? {8'hC3, uartByte} : (probe ? 16'h0000 : 16'bz));

  always @(negedge Clk)
    if (!Ram1_EN && !Ram1_WE) sram[Ram1_address[7:0]] = Ram1_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    bit          wr, rd;
    logic [15:0] addr, wdata;
    bit          dr, tb, ts;
    int          drAt, tbAt, tsAt;
    logic [15:0] expR;
    int          lat, weLow, rdnLow, wrnLow;
    logic [15:0] wrnBus;
    bit          ram;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] rdata;
    int          lat;
  } exp_t;

  exp_t sb[$];

  function automatic vec_t mk(input string n, input bit wr, input bit rd,
                              input logic [15:0] a, input logic [15:0] wd,
                              input bit dr, input bit tb, input bit ts,
                              input int drAt, input int tbAt, input int tsAt,
                              input logic [15:0] expR, input int lat, input int we,
                              input int rl, input int wl, input logic [15:0] wb,
                              input bit ram);
    vec_t v;
    v.name = n; v.wr = wr; v.rd = rd; v.addr = a; v.wdata = wd;
    v.dr = dr; v.tb = tb; v.ts = ts; v.drAt = drAt; v.tbAt = tbAt; v.tsAt = tsAt;
    v.expR = expR; v.lat = lat; v.weLow = we; v.rdnLow = rl; v.wrnLow = wl;
    v.wrnBus = wb; v.ram = ram;
    return v;
  endfunction

  task automatic runAccess(input vec_t v);
    int lat = 0;
    int weLow = 0;
    int rdnLow = 0;
    int wrnLow = 0;
    logic [15:0] wrnBus = '0;
    exp_t e;
    @(posedge Clk); #1;
    MemWrite = v.wr; MemRead = v.rd; Addr = v.addr; WData = v.wdata;
    data_ready = v.dr; tbre = v.tb; tsre = v.ts;
    sb.push_back('{v.name, v.expR, v.lat});
    #1 check({v.name, " busy@0"}, Busy, 1);
    @(posedge Clk); #1;
    Addr = ~v.addr; WData = ~v.wdata;
    while (lat < 200) begin
      @(negedge Clk);
      lat++;
      if (!Ram1_WE) weLow++;
      if (!rdn) rdnLow++;
      if (!wrn) begin wrnLow++; wrnBus = Ram1_data; end
      if (v.ram) check({v.name, " rdn/wrn"}, {rdn, wrn}, 2'b11);
      else       check({v.name, " EN"}, Ram1_EN, 1);
      if (v.ram && v.wr && !Ram1_EN) check({v.name, " wr bus"}, Ram1_data, v.wdata);
      if (v.ram && !v.wr && lat == 1) begin
        check({v.name, " EN/OE@1"}, {Ram1_EN, Ram1_OE}, 2'b00);
        check({v.name, " addr@1"}, Ram1_address, {2'b00, v.addr});
      end
      if (Done) break;
      check({v.name, " busy"}, Busy, 1);
      if (lat == v.drAt) data_ready = 1'b1;
      if (lat == v.tbAt) tbre = 1'b1;
      if (lat == v.tsAt) tsre = 1'b1;
    end
    check({v.name, " done"}, Done, 1);
    check({v.name, " busy@done"}, Busy, 0);
    e = sb.pop_front();
    check({e.name, " latency"}, lat, e.lat);
    check({e.name, " rdata"}, RData, e.rdata);
    check({v.name, " we cycles"}, weLow, v.weLow);
    check({v.name, " rdn cycles"}, rdnLow, v.rdnLow);
    check({v.name, " wrn cycles"}, wrnLow, v.wrnLow);
    if (v.wrnLow != 0) check({v.name, " wrn bus"}, wrnBus, v.wrnBus);
    @(posedge Clk); #1;
    MemRead = 1'b0; MemWrite = 1'b0;
    data_ready = 1'b0; tbre = 1'b0; tsre = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    int n;
    for (int i = 0; i < 256; i++) sram[i] = '0;
    sram[8'h10] = 16'hBEEF;

    //        name         wr rd addr      wdata     dr tb ts drAt tbAt tsAt expR      lat we rl wl wbus   ram
    vecs[0] = mk("ram_rd_4010", 0, 1, 16'h4010, 16'h0000, 0, 0, 0, 0, 0, 0, 16'hBEEF, 2, 0, 0, 0, 16'h0, 1);
    vecs[1] = mk("ram_wr_8002", 1, 0, 16'h8002, 16'h1234, 0, 0, 0, 0, 0, 0, 16'hBEEF, 5, 2, 0, 0, 16'h0, 1);
    vecs[2] = mk("ram_rd_8002", 0, 1, 16'h8002, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h1234, 2, 0, 0, 0, 16'h0, 1);
    vecs[3] = mk("rdwr_0100",   1, 1, 16'h0100, 16'h5555, 0, 0, 0, 0, 0, 0, 16'h1234, 5, 2, 0, 0, 16'h0, 1);
    vecs[4] = mk("stat_0002",   0, 1, 16'hBF01, 16'h0000, 1, 0, 0, 0, 0, 0, 16'h0002, 2, 0, 0, 0, 16'h0, 0);
    vecs[5] = mk("ram_rd_0100", 0, 1, 16'h0100, 16'h0000, 0, 0, 0, 0, 0, 0, 16'h5555, 2, 0, 0, 0, 16'h0, 1);
    vecs[6] = mk("stat_0001",   0, 1, 16'hBF01, 16'h0000, 0, 1, 1, 0, 0, 0, 16'h0001, 2, 0, 0, 0, 16'h0, 0);
    vecs[7] = mk("stat_0003",   0, 1, 16'hBF01, 16'h0000, 1, 1, 1, 0, 0, 0, 16'h0003, 2, 0, 0, 0, 16'h0, 0);
    vecs[8] = mk("stat_wr",     1, 0, 16'hBF01, 16'hFFFF, 0, 0, 0, 0, 0, 0, 16'h0003, 1, 0, 0, 0, 16'h0, 0);
    vecs[9] = mk("stat_0000",   0, 1, 16'hBF01, 16'h0000, 0, 1, 0, 0, 0, 0, 16'h0000, 2, 0, 0, 0, 16'h0, 0);

    repeat (2) @(posedge Clk);
    #1;
    check("reset strobes", {Ram1_EN, Ram1_OE, Ram1_WE, rdn, wrn}, 5'b11111);
    check("reset done", Done, 0);
    check("reset busy", Busy, 0);
    check("reset rdata", RData, 0);
    check("reset addr", Ram1_address, 0);
    Rst = 1'b1;

    foreach (vecs[i]) runAccess(vecs[i]);

    uartByte = 8'h5A;
    runAccess(mk("uart_rd", 0, 1, 16'hBF00, 16'h0000, 0, 0, 0, 4, 0, 0,
                 16'h005A, 6, 0, 1, 0, 16'h0, 0));
    runAccess(mk("uart_wr", 1, 0, 16'hBF00, 16'hAB41, 0, 0, 0, 0, 5, 7,
                 16'h005A, 8, 0, 0, 1, 16'h0041, 0));

    // Async reset in the middle of an SRAM write pulse.
    @(posedge Clk); #1;
    MemWrite = 1'b1; Addr = 16'h8004; WData = 16'h7777;
    n = 0;
    while (Ram1_WE && n < 20) begin @(negedge Clk); n++; end
    check("rst: in pulse", Ram1_WE, 0);
    #2 Rst = 1'b0;
    #1;
    check("rst: WE", Ram1_WE, 1);
    check("rst: EN", Ram1_EN, 1);
    check("rst: Done", Done, 0);
    check("rst: rdata", RData, 0);
    check("rst: addr", Ram1_address, 0);
    probe = 1'b1;
    #1 check("rst: bus released", Ram1_data, 16'h0000);
    probe = 1'b0;
    MemWrite = 1'b0;
    @(posedge Clk); #1;
    Rst = 1'b1;
    runAccess(mk("post_rst_rd", 0, 1, 16'h4010, 16'h0000, 0, 0, 0, 0, 0, 0,
                 16'hBEEF, 2, 0, 0, 0, 16'h0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Sequences every data-memory access issued by the MEM stage onto the shared Ram1 SRAM bus and the on-board UART, which share the Ram1_data lines.
- Converts a single-cycle MemRead/MemWrite request into correctly timed SRAM and UART strobe sequences.
- Stalls the pipeline through Busy until the access completes.
- Sits between the ex_mem register and the board pins, replacing direct pin driving by dm.

Parameters:
- UART_DATA_ADDR, 16'hBF00, address selecting the UART data register.
- UART_STAT_ADDR, 16'hBF01, address selecting the UART status register.
- WR_PULSE, 2, number of cycles Ram1_WE is held low on an SRAM write (1..7).

Ports:
- Clk  in  1  system clock, all state changes on rising edge
- Rst  in  1  asynchronous reset, active-low
- MemRead  in  1  read request from MEM stage, held until Done
- MemWrite  in  1  write request from MEM stage, held until Done
- Addr  in  16  access address (Result2)
- WData  in  16  store data (DataIn2)
- RData  out  16  load data, registered
- Done  out  1  one-cycle completion pulse
- Busy  out  1  combinational stall: (MemRead|MemWrite) & ~Done
- Ram1_EN  out  1  SRAM chip enable, active-low
- Ram1_OE  out  1  SRAM output enable, active-low
- Ram1_WE  out  1  SRAM write enable, active-low
- Ram1_address  out  18  SRAM address
- Ram1_data  inout  16  shared SRAM/UART data bus
- rdn  out  1  UART read strobe, active-low
- wrn  out  1  UART write strobe, active-low
- data_ready  in  1  UART receive byte available
- tbre  in  1  UART transmit buffer empty
- tsre  in  1  UART transmit shift register empty

Behaviour:
- Reset (async, Rst=0), taking effect immediately, including mid-operation:
  - State forced to IDLE.
  - Ram1_EN, Ram1_OE, Ram1_WE, rdn and wrn all forced to 1.
  - Ram1_address=0, Ram1_data=Z, RData=0, Done=0.
- Request acceptance:
  - Requests are sampled only in IDLE. Addr and WData are latched on acceptance; later input changes are ignored.
  - If MemWrite and MemRead are both high, MemWrite has priority and the read is ignored.
  - In DONE, requests are ignored and the next state is IDLE. The requester must drop its request in the cycle after Done.
- Ram1_address={2'b00, latched Addr} whenever Ram1_EN=0.
- Ram1_data is driven only in write states; it is Z otherwise.
- rdn=wrn=1 during SRAM states. Ram1_EN=1 during UART states.
- States and transitions, with cycle 0 = accept edge:
  - IDLE -> RAM_RD / RAM_WR_SETUP / UART_RD_WAIT / UART_WR_SETUP / STAT / stay, chosen by request type and address match.
  - RAM_RD: EN=0, OE=0. On the next edge, RData<=Ram1_data and go to DONE. Done is seen at cycle 2.
  - RAM_WR_SETUP: EN=0, WE=1, data driven -> RAM_WR_PULSE.
  - RAM_WR_PULSE: WE=0 for exactly WR_PULSE cycles (counter), data driven -> RAM_WR_HOLD.
  - RAM_WR_HOLD: WE=1, data still driven -> DONE. Done at cycle 3+WR_PULSE.
  - STAT (read of UART_STAT_ADDR): RData<={14'b0, data_ready, tbre&tsre} -> DONE. No bus activity.
  - UART_RD_WAIT: remain while data_ready=0; else -> UART_RD_PULSE.
  - UART_RD_PULSE: rdn=0 for 1 cycle; RData<={8'b0, Ram1_data[7:0]} on the exit edge -> DONE.
  - UART_WR_SETUP: data={8'b0, WData[7:0]} driven -> UART_WR_PULSE.
  - UART_WR_PULSE: wrn=0 for 1 cycle, data driven -> UART_WR_WAIT_TBRE.
  - UART_WR_WAIT_TBRE: wait for tbre=1 -> UART_WR_WAIT_TSRE.
  - UART_WR_WAIT_TSRE: wait for tsre=1 -> DONE.
  - DONE: Done=1 for exactly one cycle -> IDLE.
- Writes to UART_STAT_ADDR complete with no bus activity: IDLE -> DONE.
- Waits have no timeout; Busy stays high for their whole duration.
- RData holds its value until the next read completes.
- Strobe outputs are registered, so there are no combinational glitches on EN/OE/WE/rdn/wrn.

Test Plan:
- Reset mid-RAM_WR_PULSE (WE=0), pulse Rst low:
  - WE=1, EN=1, data Z, Done=0 immediately.
  - A MemRead after release completes normally.
- MemRead Addr=16'h4010 with the SRAM model returning 16'hBEEF:
  - EN=OE=0 with address 18'h04010 at cycle 1.
  - Done at cycle 2, RData=16'hBEEF.
  - Busy high for cycles 0-1.
- MemWrite Addr=16'h8002, WData=16'h1234, WR_PULSE=2:
  - WE low exactly 2 cycles, with data 16'h1234 stable from setup through hold.
  - Done at cycle 5; rdn=wrn=1 throughout.
- MemRead 16'hBF00 with data_ready held 0 for 4 cycles, then 1, UART byte 8'h5A:
  - Stalls 4 cycles, then rdn low for 1 cycle.
  - RData=16'h005A, Ram1_EN=1 throughout.
- MemWrite 16'hBF00, WData=16'hAB41, with tbre delayed 3 cycles and tsre 2 cycles later:
  - wrn pulses once with bus=16'h0041.
  - Done only after tsre=1.
- Simultaneous MemRead+MemWrite to 16'h0100, then MemRead 16'hBF01 with data_ready=1, tbre=tsre=0:
  - First request performs a write only.
  - Status read returns RData=16'h0002 with Done at cycle 2.
